mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters:
  - the CPU multicycle control/datapath (port 0);
  - the host loader/debug port (port 1).
- Serialises accesses with two-way round-robin arbitration.
- Drives one registered memory transaction at a time, with programmable read latency.
- Returns read data and a one-cycle ack to the winning requester. Sits between the control/datapath memory-address mux and the memory macro.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- RD_LAT, 1, cycles from mem_re to valid mem_rdata; legal range 1..7.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  DATA_W  CPU read data; valid while cpu_ack = 1.
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host equivalents of the CPU inputs.
- host_ack, host_rdata  out  1/DATA_W  host equivalents of the CPU outputs.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  DATA_W  memory read data.
- grant  out  1  owner of the current transaction (0 = CPU, 1 = host).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state = IDLE, last_grant = 1 (so the CPU wins the first tie), grant = 0.
  - mem_we = mem_re = 0, mem_addr = mem_wdata = 0.
  - cpu_ack = host_ack = 0, cpu_rdata = host_rdata = 0, busy = 0, latency counter = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Single request: grant that requester.
  - Both requesting: grant the port not equal to last_grant.
  - On grant: latch addr, wdata, we and grant; update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_we = latched we; mem_re = ~latched we.
  - Write: go to DONE.
  - Read: load counter with RD_LAT-1, go to WAIT.
- WAIT:
  - Decrement the counter.
  - When the counter = 0, capture mem_rdata into the granted port's rdata register and go to DONE.
  - RD_LAT = 1 still passes through WAIT for one cycle.
- DONE (1 cycle):
  - Granted port's ack = 1; the other port's ack = 0; then go to IDLE.
- Latency, with the request sampled in IDLE at cycle T:
  - Write: mem_we in T+1, ack in T+2.
  - Read: mem_re in T+1, ack in T+2+RD_LAT.
- Handshake:
  - A requester holds req, we, addr and wdata stable from assertion until its ack.
  - It deasserts req in the cycle after ack.
  - Requests arriving while busy wait; they are never dropped.
- Output holding:
  - rdata of the non-granted port is held unchanged.
  - The granted port's rdata holds its value after ack until that port's next read.
- Strobes: mem_we and mem_re are never high together and are high only in ISSUE.
- Fairness:
  - With both ports requesting continuously, grants alternate CPU, host, CPU, …
  - Neither port waits more than one foreign transaction.
- Reset mid-operation: on the next edge return to IDLE with all reset values; no ack is issued for the aborted transaction.
- Pipelining: no back-to-back issue; IDLE is always visited between transactions (one bubble cycle).
- Illegal input: req deasserted before ack does not abort the in-flight transaction; ack is still pulsed.

Decomposition:
- Shared package (mem_arb_pkg):
  - State encodings: IDLE = 0, ISSUE = 1, WAIT = 2, DONE = 3.
  - Grant constants: GNT_CPU = 0, GNT_HOST = 1.
  - Default widths: 16 for address and data.
- Sub-module mem_arb_rr: combinational two-way round-robin pick.
  - Inputs: req[1:0], last_grant.
  - Outputs: valid, pick.
- All transaction FSM, counter and storage logic live in the top module.

Test Plan:
- Single CPU write: cpu_req with we = 1, addr = 0x0010, wdata = 0xBEEF at T → mem_we = 1 with addr 0x0010 / data 0xBEEF in T+1; cpu_ack in T+2; host_ack stays 0.
- Single host read, RD_LAT = 3, memory returns 0x1234: host_req at T → mem_re in T+1; host_ack in T+5 with host_rdata = 0x1234; cpu_rdata unchanged.
- Simultaneous requests from reset, both held: grant sequence CPU, host, CPU across 3 transactions; busy drops for exactly one cycle between transactions.
- Contention mid-transaction: host_req rises during a CPU read's WAIT → host is granted on the first IDLE after cpu_ack; CPU data is intact.
- Reset asserted in WAIT of a read → next cycle: state IDLE, mem_re = 0, no ack; a subsequent CPU read completes normally.
- RD_LAT = 1 back-to-back CPU reads of 0x0000 then 0x0001 → acks at T+3 and T+7 with the correct data each.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// grant identifiers and default address/data widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic GNT_CPU  = 1'b0;
    localparam logic GNT_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick.
//   req[1:0]   : request vector (bit 0 = CPU, bit 1 = host)
//   last_grant : port granted most recently
//   valid      : at least one request present
//   pick       : chosen port (only meaningful when valid)
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |req;
        if (req == 2'b11)
            pick = ~last_grant;   // tie goes to whoever did not win last time
        else if (req[1])
            pick = GNT_HOST;
        else
            pick = GNT_CPU;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU (port 0) and the host
// loader/debug port (port 1). One transaction at a time, round-robin on ties,
// programmable read latency.
//   CLK, Reset                          : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_ack/rdata: CPU request/response
//   host_req/we/addr/wdata, host_ack/rdata: host request/response
//   mem_addr/wdata/we/re, mem_rdata     : memory macro interface
//   grant                               : owner of current transaction
//   busy                                : FSM not in IDLE
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant,
    output logic              busy
);

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    arb_state_t state, state_nxt;
    logic       last_grant;
    logic       lat_we;
    logic [2:0] cnt;
    logic       rr_valid, rr_pick;

    mem_arb_rr u_rr (
        .req        ({host_req, cpu_req}),
        .last_grant (last_grant),
        .valid      (rr_valid),
        .pick       (rr_pick)
    );

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        cpu_ack   = 1'b0;
        host_ack  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (rr_valid) state_nxt = ISSUE;
            ISSUE: begin
                mem_we    = lat_we;
                mem_re    = ~lat_we;
                state_nxt = lat_we ? DONE : WAIT;
            end
            WAIT:  if (cnt == 3'd0) state_nxt = DONE;
            DONE: begin
                cpu_ack   = (grant == GNT_CPU);
                host_ack  = (grant == GNT_HOST);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            last_grant <= GNT_HOST;   // CPU wins the first tie
            grant      <= GNT_CPU;
            lat_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cnt        <= 3'd0;
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (rr_valid) begin
                    grant      <= rr_pick;
                    last_grant <= rr_pick;
                    lat_we     <= rr_pick ? host_we    : cpu_we;
                    mem_addr   <= rr_pick ? host_addr  : cpu_addr;
                    mem_wdata  <= rr_pick ? host_wdata : cpu_wdata;
                end
                ISSUE: if (!lat_we) cnt <= CNT_INIT;
                WAIT: begin
                    // cnt reaches 0 on the cycle mem_rdata becomes valid
                    if (cnt == 3'd0) begin
                        if (grant == GNT_HOST) host_rdata <= mem_rdata;
                        else                   cpu_rdata  <= mem_rdata;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
